// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin (or fixed-priority with ALU_ARB_FIXED_PRI_EN) sharing of one ALU32 among NREQ requesters.
// ALU op encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, others yield 0.
module alu32 #(
  parameter int WIDTH = 32,
  parameter int OPW = 6
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] sh;
  assign sh = in2[SW-1:0];
  always_comb begin
    out = '0;
    case (op)
      OPW'(0): out = in1 + in2;
      OPW'(1): out = in1 - in2;
      OPW'(2): out = in1 & in2;
      OPW'(3): out = in1 | in2;
      OPW'(4): out = in1 ^ in2;
      OPW'(5): out = in1 << sh;
      OPW'(6): out = in1 >> sh;
      OPW'(7): out = $signed(in1) >>> sh;
      OPW'(8): out = WIDTH'($signed(in1) < $signed(in2));
      OPW'(9): out = WIDTH'(in1 < in2);
      default: out = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int OPW = 6,
  parameter int IDW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  input  logic [NREQ*WIDTH-1:0] req_in2,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data
);
  logic [IDW-1:0] g;
  logic any, free, xfer;
  logic [WIDTH-1:0] alu_out;
`ifdef ALU_ARB_FIXED_PRI_EN
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[k]) begin
        g = IDW'(k);
        any = 1'b1;
      end
  end
`else
  logic [IDW-1:0] rr, idx;
  // Scan backwards so the last hit is the first index at or after rr.
  always_comb begin
    g = '0;
    any = 1'b0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr) + k) % NREQ);
      if (req_valid[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
`endif
  assign free = !resp_valid || resp_ready;
  assign xfer = any && free && !reset;
  assign req_ready = xfer ? NREQ'(1) << g : '0;
  alu32 #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .op (req_op[g*OPW +: OPW]),
    .in1(req_in1[g*WIDTH +: WIDTH]),
    .in2(req_in2[g*WIDTH +: WIDTH]),
    .out(alu_out)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
`ifndef ALU_ARB_FIXED_PRI_EN
      rr <= '0;
`endif
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_data <= '0;
    end else begin
      if (free) resp_valid <= xfer;
      if (xfer) begin
        resp_data <= alu_out;
        resp_id <= g;
`ifndef ALU_ARB_FIXED_PRI_EN
        rr <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter; honours ALU_ARB_FIXED_PRI_EN like the design.
module tb_alu_arbiter;
  localparam int NREQ = 4, WIDTH = 32, OPW = 6, IDW = 2;
  logic clk = 1'b0, reset = 1'b1, resp_ready = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic [NREQ*WIDTH-1:0] req_in1 = '0, req_in2 = '0;
  logic resp_valid;
  logic [IDW-1:0] resp_id;
  logic [WIDTH-1:0] resp_data;
  always #5 clk = ~clk;
  alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .OPW(OPW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data)
  );
  int vectors = 0, miscompares = 0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic [IDW-1:0] id; logic [WIDTH-1:0] data;} rsp_t;
  rsp_t sb[$];
  logic m_valid = 1'b0;
  int m_rr = 0, g;
  logic [NREQ-1:0] acc = '0;
  int left[NREQ] = '{default: 0};
  function automatic logic [WIDTH-1:0] alu(logic [OPW-1:0] op, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[4:0];
      6: return a >> b[4:0];
      7: return $signed(a) >>> b[4:0];
      8: return {31'b0, $signed(a) < $signed(b)};
      9: return {31'b0, a < b};
      default: return '0;
    endcase
  endfunction
  function automatic int grant_of(logic [NREQ-1:0] v, int rr);
    for (int k = 0; k < NREQ; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
      if (v[k]) return k;
`else
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
`endif
    end
    return -1;
  endfunction
  always @(negedge clk) begin
    if (reset) begin
      check("ready_in_reset", req_ready, 0);
      sb.delete();
      m_valid = 1'b0;
      m_rr = 0;
      acc = '0;
    end else begin
      check("resp_valid", resp_valid, m_valid);
      if (m_valid && sb.size() > 0) begin
        check("resp_id", resp_id, sb[0].id);
        check("resp_data", resp_data, sb[0].data);
      end
      g = (!m_valid || resp_ready) ? grant_of(req_valid, m_rr) : -1;
      check("req_ready", req_ready, g < 0 ? 0 : 1 << g);
      if (m_valid && resp_ready) void'(sb.pop_front());
      acc = g < 0 ? '0 : NREQ'(1) << g;
      if (!m_valid || resp_ready) m_valid = g >= 0;
      if (g >= 0) begin
        sb.push_back('{id: IDW'(g), data: alu(req_op[g*OPW +: OPW], req_in1[g*WIDTH +: WIDTH], req_in2[g*WIDTH +: WIDTH])});
        m_rr = (g == NREQ - 1) ? 0 : g + 1;
      end
    end
  end
  task automatic load(int i);
    req_op[i*OPW +: OPW] = OPW'($urandom_range(0, 9));
    req_in1[i*WIDTH +: WIDTH] = $urandom;
    req_in2[i*WIDTH +: WIDTH] = $urandom;
    req_valid[i] = 1'b1;
  endtask
  // Requesters hold payload until accepted, then reload or retire with a scrambled payload.
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          left[i]--;
          if (left[i] > 0) load(i);
          else begin
            req_valid[i] = 1'b0;
            req_in1[i*WIDTH +: WIDTH] = $urandom;
            req_op[i*OPW +: OPW] = OPW'($urandom_range(0, 9));
          end
        end else if (!req_valid[i] && left[i] > 0) load(i);
      end
      acc = '0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while ((left.sum() > 0 || sb.size() > 0 || m_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("drain_timeout", 1, 0);
  endtask
  initial begin
    tick(2);
    @(negedge clk);
    check("rst_valid", resp_valid, 0);
    check("rst_data", resp_data, 0);
    check("rst_id", resp_id, 0);
    tick();
    reset = 1'b0;
    req_op[0 +: OPW] = 0;
    req_in1[0 +: WIDTH] = 32'h5;
    req_in2[0 +: WIDTH] = 32'h3;
    req_valid[0] = 1'b1;
    left[0] = 1;
    @(negedge clk);
    check("t1_ready", req_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("t1_valid", resp_valid, 1);
    check("t1_id", resp_id, 0);
    check("t1_data", resp_data, 32'h8);
    tick();
    @(negedge clk);
    check("t1_idle", resp_valid, 0);
    for (int i = 0; i < NREQ; i++) left[i] = 8;
    tick();
    drain();
    resp_ready = 1'b0;
    left[0] = 1;
    tick(2);
    left[1] = 1;
    left[2] = 1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    drain();
    left[2] = 1;
    drain();
    left[3] = 1;
    left[0] = 1;
    tick();
`ifndef ALU_ARB_FIXED_PRI_EN
    @(negedge clk);
    check("wrap_first", req_ready, 4'b1000);
    tick();
    @(negedge clk);
    check("wrap_second", req_ready, 4'b0001);
`endif
    drain();
    req_op[1*OPW +: OPW] = 1;
    req_in1[1*WIDTH +: WIDTH] = 32'h0;
    req_in2[1*WIDTH +: WIDTH] = 32'h1;
    req_valid[1] = 1'b1;
    left[1] = 1;
    tick();
    @(negedge clk);
    check("sub_data", resp_data, 32'hFFFF_FFFF);
    drain();
    resp_ready = 1'b0;
    left[0] = 1;
    tick(3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_stalled_ready", req_ready, 0);
    tick();
    @(negedge clk);
    check("rst_flush_valid", resp_valid, 0);
    check("rst_flush_data", resp_data, 0);
    tick();
    reset = 1'b0;
    resp_ready = 1'b1;
    left[1] = 1;
    left[0] = 1;
    tick();
    @(negedge clk);
    check("post_rst_grant", req_ready, 4'b0001);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
